// File: rtl/pudp_pkg.sv
// Shared types for the PUDP demux: FSM states, drop reasons and the 9-bit buffer entry.
package pudp_pkg;

    localparam int PUDP_MIN_LEN = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } pudp_st_e;

    typedef enum logic [1:0] {
        CKSUM   = 2'd0,
        OVFL    = 2'd1,
        BADTYPE = 2'd2,
        RUNT    = 2'd3
    } pudp_drop_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } pudp_ent_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pudp_pkt_fifo.sv
// Per-channel packet store-and-forward buffer: tentative writes that commit or roll back,
// read side exposes only committed entries through a RAM-read stage and an AXI-Stream register.
module pudp_pkt_fifo
    import pudp_pkg::*;
#(
    parameter int DEPTH = 2048
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      wr_en_i,
    input  pudp_ent_t wr_ent_i,
    input  logic      commit_i,
    input  logic      rollback_i,
    output logic      free_o,
    output logic      m_tvalid_o,
    input  logic      m_tready_i,
    output logic [7:0] m_tdata_o,
    output logic      m_tlast_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] tent_q, tent_d, cmt_q, cmt_d, rd_q, rd_d, tent_nx;
    pudp_ent_t     mem [DEPTH];
    pudp_ent_t     ram_q, out_q, out_d, skid_q, skid_d;
    logic          ram_vld_q, out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic          empty, pop, rd_en;
    logic [1:0]    in_use;

    assign free_o  = (tent_q - rd_q) != PW'(DEPTH);
    assign empty   = (cmt_q == rd_q);
    assign tent_nx = wr_en_i ? tent_q + PW'(1) : tent_q;

    always_comb begin
        tent_d = rollback_i ? cmt_q : tent_nx;
        cmt_d  = commit_i ? tent_nx : cmt_q;
    end

    // Reads are issued only while the RAM stage, output register and skid slot
    // can absorb the result, so nothing is lost when the consumer stalls.
    always_comb begin
        pop    = out_vld_q && m_tready_i;
        in_use = 2'(ram_vld_q) + 2'(out_vld_q) + 2'(skid_vld_q) - 2'(pop);
        rd_en  = !empty && (in_use < 2'd2);
        rd_d   = rd_q + PW'(rd_en);
    end

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = ram_vld_q;
                if (ram_vld_q) skid_d = ram_q;
            end else begin
                out_vld_d = ram_vld_q;
                if (ram_vld_q) out_d = ram_q;
            end
        end else if (ram_vld_q) begin
            skid_d     = ram_q;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[tent_q[AW-1:0]] <= wr_ent_i;
        if (rd_en)   ram_q <= mem[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tent_q     <= '0;
            cmt_q      <= '0;
            rd_q       <= '0;
            ram_vld_q  <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            tent_q     <= tent_d;
            cmt_q      <= cmt_d;
            rd_q       <= rd_d;
            ram_vld_q  <= rd_en;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign m_tvalid_o = out_vld_q;
    assign m_tdata_o  = out_q.data;
    assign m_tlast_o  = out_q.last;

endmodule

// File: rtl/pudp_demux.sv
// PUDP packet demux: validates type/payload/XOR-checksum packets and steers good payloads
// into per-channel buffers. Define PUDP_DEMUX_STATS_EN to add the good/drop counters.
module pudp_demux
    import pudp_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2048
) (
    input  logic                 clki,
    input  logic                 rsti_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic [NUM_CH-1:0]    m_axis_tvalid,
    input  logic [NUM_CH-1:0]    m_axis_tready,
    output logic [NUM_CH*8-1:0]  m_axis_tdata,
    output logic [NUM_CH-1:0]    m_axis_tlast
`ifdef PUDP_DEMUX_STATS_EN
    ,
    output logic [NUM_CH*16-1:0] stat_good,
    output logic [4*16-1:0]      stat_drop
`endif
);

    pudp_st_e    state_q, state_d;
    logic [7:0]  type_q, type_d, xor_q, xor_d, prev_q, prev_d;
    logic [1:0]  len_q, len_d;
    logic        drop_q, drop_d, rdy_q;
    logic        acc, short_pkt, ch_free, drop_now, wr_req, cmt, rb;
    logic [NUM_CH-1:0] wr_v, cmt_v, rb_v, free_v;
    pudp_ent_t   wr_ent;

    assign acc           = s_axis_tvalid && rdy_q;
    assign s_axis_tready = rdy_q;
    // len_q saturates at 2: from then on the held byte is payload.
    assign short_pkt     = (int'(len_q) + 1) < PUDP_MIN_LEN;
    assign wr_ent        = '{last: s_axis_tlast, data: prev_q};

    always_comb begin
        ch_free = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(type_q) == c) ch_free = free_v[c];
        end
    end

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        xor_d    = xor_q;
        prev_d   = prev_q;
        len_d    = len_q;
        drop_d   = drop_q;
        drop_now = drop_q;
        wr_req   = 1'b0;
        cmt      = 1'b0;
        rb       = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    type_d  = s_axis_tdata;
                    xor_d   = s_axis_tdata;
                    len_d   = 2'd1;
                    drop_d  = int'(s_axis_tdata) >= NUM_CH;
                    state_d = s_axis_tlast ? IDLE : BODY;
                end
            end
            BODY: begin
                if (acc) begin
                    xor_d  = xor_q ^ s_axis_tdata;
                    prev_d = s_axis_tdata;
                    len_d  = (len_q == 2'd2) ? 2'd2 : len_q + 2'd1;
                    if (len_q == 2'd2) begin
                        drop_now = drop_q || !ch_free;
                        wr_req   = !drop_now;
                    end
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                        if (!short_pkt && !drop_now && (xor_q == s_axis_tdata)) cmt = 1'b1;
                        else                                                    rb  = 1'b1;
                    end else begin
                        drop_d = drop_now;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_v  = '0;
        cmt_v = '0;
        rb_v  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(type_q) == c) begin
                wr_v[c]  = wr_req;
                cmt_v[c] = cmt;
                rb_v[c]  = rb;
            end
        end
    end

    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            state_q <= IDLE;
            type_q  <= '0;
            xor_q   <= '0;
            prev_q  <= '0;
            len_q   <= '0;
            drop_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            xor_q   <= xor_d;
            prev_q  <= prev_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
            rdy_q   <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pudp_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_i      (clki),
            .rst_ni     (rsti_n),
            .wr_en_i    (wr_v[c]),
            .wr_ent_i   (wr_ent),
            .commit_i   (cmt_v[c]),
            .rollback_i (rb_v[c]),
            .free_o     (free_v[c]),
            .m_tvalid_o (m_axis_tvalid[c]),
            .m_tready_i (m_axis_tready[c]),
            .m_tdata_o  (m_axis_tdata[8*c +: 8]),
            .m_tlast_o  (m_axis_tlast[c])
        );
    end

`ifdef PUDP_DEMUX_STATS_EN
    logic [NUM_CH-1:0][15:0] good_cnt_q;
    logic [3:0][15:0]        drop_cnt_q;
    logic                    pkt_end, ev_runt, ev_bad, ev_ovfl, ev_cks;

    // One reason per dropped packet, in priority runt > bad type > overflow > checksum.
    assign pkt_end = acc && s_axis_tlast;
    assign ev_runt = pkt_end && ((state_q == IDLE) || short_pkt);
    assign ev_bad  = pkt_end && !ev_runt && (int'(type_q) >= NUM_CH);
    assign ev_ovfl = pkt_end && !ev_runt && !ev_bad && drop_now;
    assign ev_cks  = rb && !ev_runt && !ev_bad && !ev_ovfl;

    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cmt_v[c]) good_cnt_q[c] <= sat_inc16(good_cnt_q[c]);
            end
            if (ev_cks)  drop_cnt_q[int'(CKSUM)]   <= sat_inc16(drop_cnt_q[int'(CKSUM)]);
            if (ev_ovfl) drop_cnt_q[int'(OVFL)]    <= sat_inc16(drop_cnt_q[int'(OVFL)]);
            if (ev_bad)  drop_cnt_q[int'(BADTYPE)] <= sat_inc16(drop_cnt_q[int'(BADTYPE)]);
            if (ev_runt) drop_cnt_q[int'(RUNT)]    <= sat_inc16(drop_cnt_q[int'(RUNT)]);
        end
    end

    assign stat_good = good_cnt_q;
    assign stat_drop = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pudp_demux.sv
// Scoreboard bench for pudp_demux: packet-level reference model feeds per-channel queues,
// a forked monitor pops and compares every output transfer and checks stall stability.
module tb_pudp_demux;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam int R_CKS  = 0;
    localparam int R_OVF  = 1;
    localparam int R_BAD  = 2;
    localparam int R_RUNT = 3;

    typedef logic [7:0] bq_t[$];

    logic clki = 1'b0;
    logic rsti_n = 1'b1;
    logic s_tvalid = 1'b0;
    logic s_tready;
    logic [7:0] s_tdata = 8'h00;
    logic s_tlast = 1'b0;
    logic [NUM_CH-1:0] m_tvalid, m_tready, m_tlast;
    logic [NUM_CH*8-1:0] m_tdata;
    logic [NUM_CH-1:0] rdy_main = '1;
    logic rdy1_rand = 1'b1;
    logic rand_en = 1'b0;
`ifdef PUDP_DEMUX_STATS_EN
    logic [NUM_CH*16-1:0] stat_good;
    logic [4*16-1:0]      stat_drop;
`endif

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q [NUM_CH][$];
    int popped_b [NUM_CH];
    int popped_l [NUM_CH];
    int exp_good [NUM_CH];
    int exp_drop [4];

    assign m_tready = rand_en ? {rdy_main[3:2], rdy1_rand, rdy_main[0]} : rdy_main;

    always #5 clki = ~clki;

    pudp_demux #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clki          (clki),
        .rsti_n        (rsti_n),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast)
`ifdef PUDP_DEMUX_STATS_EN
        ,
        .stat_good     (stat_good),
        .stat_drop     (stat_drop)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic monitor();
        logic [8:0] held_v [NUM_CH];
        logic [NUM_CH-1:0] held;
        logic [8:0] cur, e;
        held = '0;
        forever begin
            @(negedge clki);
            if (!rsti_n) begin
                held = '0;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    cur = {m_tlast[c], m_tdata[8*c +: 8]};
                    if (held[c])
                        chk($sformatf("ch%0d_stall_hold", c), {m_tvalid[c], cur}, {1'b1, held_v[c]});
                    if (m_tvalid[c] && m_tready[c]) begin
                        popped_b[c]++;
                        if (cur[8]) popped_l[c]++;
                        if (exp_q[c].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL ch%0d_unexpected: got %03h expected no output", c, cur);
                        end else begin
                            e = exp_q[c].pop_front();
                            chk($sformatf("ch%0d_data", c), 32'(cur), 32'(e));
                        end
                    end
                    held[c]   = m_tvalid[c] && !m_tready[c];
                    held_v[c] = cur;
                end
            end
        end
    endtask

    task automatic rand_ready();
        forever begin
            @(posedge clki);
            #1;
            rdy1_rand = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clki);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = b;
        s_tlast  = last;
        @(posedge clki);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Packet-level model: decides the fate of the whole packet from its bytes.
    task automatic send_pkt(input bq_t p, input bit gaps);
        int n, ch, rsn;
        logic [7:0] x;
        n  = p.size();
        ch = int'(p[0]);
        x  = 8'h00;
        for (int i = 0; i < n - 1; i++) x ^= p[i];
        if (n < 3)                                rsn = R_RUNT;
        else if (ch >= NUM_CH)                    rsn = R_BAD;
        else if (exp_q[ch].size() + n - 2 > DEPTH) rsn = R_OVF;
        else if (x != p[n-1])                     rsn = R_CKS;
        else                                      rsn = -1;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) tick(1);
            send_byte(p[i], i == n - 1);
        end
        if (rsn < 0) begin
            for (int i = 1; i <= n - 2; i++) exp_q[ch].push_back({i == n - 2, p[i]});
            exp_good[ch]++;
        end else begin
            exp_drop[rsn]++;
        end
    endtask

    function automatic bq_t mkq(input int n, input logic [31:0] w);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(w[31-8*i -: 8]);
        return q;
    endfunction

    function automatic bq_t mk_pkt(input logic [7:0] t, input int n, input bit bad);
        bq_t q;
        logic [7:0] x, b;
        q.push_back(t);
        x = t;
        for (int i = 1; i < n - 1; i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            x ^= b;
        end
        if (n >= 2) q.push_back(bad ? x ^ 8'($urandom_range(1, 255)) : x);
        return q;
    endfunction

    task automatic wait_space(input int ch, input int pay);
        int cyc = 0;
        while (exp_q[ch].size() + pay > DEPTH && cyc < 1000) begin
            tick(1);
            cyc++;
        end
        if (cyc >= 1000) begin
            checks++;
            errors++;
            $display("FAIL space_timeout ch%0d: queued %0d required <= %0d", ch, exp_q[ch].size(), DEPTH - pay);
        end
    endtask

    task automatic wait_drain(input int budget);
        int cyc = 0;
        bit busy = 1'b1;
        while (busy && cyc < budget) begin
            busy = (m_tvalid != '0);
            for (int c = 0; c < NUM_CH; c++) if (exp_q[c].size() != 0) busy = 1'b1;
            if (busy) begin
                tick(1);
                cyc++;
            end
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending output after %0d cycles, required none", budget);
        end
        tick(3);
    endtask

`ifdef PUDP_DEMUX_STATS_EN
    task automatic chk_stats(input string tag);
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("%s_good%0d", tag, c), 32'(stat_good[16*c +: 16]), 32'(exp_good[c]));
        for (int r = 0; r < 4; r++)
            chk($sformatf("%s_drop%0d", tag, r), 32'(stat_drop[16*r +: 16]), 32'(exp_drop[r]));
    endtask
`endif

    initial begin
        int b0, l0, ch, n;
        for (int c = 0; c < NUM_CH; c++) begin
            popped_b[c] = 0;
            popped_l[c] = 0;
            exp_good[c] = 0;
        end
        for (int r = 0; r < 4; r++) exp_drop[r] = 0;

        #1 rsti_n = 1'b0;
        fork
            monitor();
            rand_ready();
        join_none
        tick(3);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        rsti_n = 1'b1;
        tick(2);
        chk("run_s_tready", 32'(s_tready), 1);

        send_pkt(mkq(4, 32'h02AABB13), 0);
        wait_drain(200);
        chk("good_ch2_bytes", 32'(popped_b[2]), 2);
        chk("good_ch2_lasts", 32'(popped_l[2]), 1);
`ifdef PUDP_DEMUX_STATS_EN
        chk_stats("good");
`endif

        send_pkt(mkq(4, 32'h02AABB14), 0);
        wait_drain(200);
        chk("badck_no_output", 32'(popped_b[2]), 2);
        send_pkt(mkq(4, 32'h02AABB13), 0);
        wait_drain(200);
        chk("after_badck_bytes", 32'(popped_b[2]), 4);

        send_pkt(mkq(3, 32'h05AAAF00), 0);
        send_pkt(mkq(2, 32'h01010000), 0);
        send_pkt(mkq(1, 32'h01000000), 0);
        wait_drain(200);
`ifdef PUDP_DEMUX_STATS_EN
        chk_stats("drops");
`endif

        b0 = popped_b[0];
        l0 = popped_l[0];
        rdy_main[0] = 1'b0;
        for (int k = 0; k < 3; k++) send_pkt(mk_pkt(8'h00, 9, 1'b0), 0);
        tick(20);
        chk("ovfl_stalled", 32'(popped_b[0] - b0), 0);
        rdy_main[0] = 1'b1;
        wait_drain(300);
        chk("ovfl_bytes", 32'(popped_b[0] - b0), 14);
        chk("ovfl_lasts", 32'(popped_l[0] - l0), 2);
`ifdef PUDP_DEMUX_STATS_EN
        chk_stats("ovfl");
`endif

        rand_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ch = ($urandom_range(0, 1) == 1) ? 3 : 1;
            n  = int'($urandom_range(3, 8));
            wait_space(ch, n - 2);
            send_pkt(mk_pkt(8'(ch), n, 1'b0), 1);
        end
        wait_drain(2000);

        for (int k = 0; k < 24; k++) begin
            ch = int'($urandom_range(0, 5));
            n  = int'($urandom_range(1, 9));
            if (ch < NUM_CH && n >= 3) wait_space(ch, n - 2);
            send_pkt(mk_pkt(8'(ch), n, $urandom_range(0, 3) == 0), 1);
        end
        wait_drain(2000);
        rand_en = 1'b0;
`ifdef PUDP_DEMUX_STATS_EN
        chk_stats("mixed");
`endif

        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        rsti_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", 32'(m_tvalid), 0);
        chk("midrst_m_tdata", m_tdata, 0);
        chk("midrst_m_tlast", 32'(m_tlast), 0);
        chk("midrst_s_tready", 32'(s_tready), 0);
        for (int c = 0; c < NUM_CH; c++) exp_good[c] = 0;
        for (int r = 0; r < 4; r++) exp_drop[r] = 0;
        tick(3);
        rsti_n = 1'b1;
        tick(2);
        chk("postrst_s_tready", 32'(s_tready), 1);
        b0 = popped_b[0];
        l0 = popped_l[0];
        send_pkt(mkq(3, 32'h00555500), 0);
        wait_drain(200);
        chk("postrst_bytes", 32'(popped_b[0] - b0), 1);
        chk("postrst_lasts", 32'(popped_l[0] - l0), 1);
`ifdef PUDP_DEMUX_STATS_EN
        chk_stats("postrst");
`endif

        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("end_queue_ch%0d", c), 32'(exp_q[c].size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pudp_demux.md
# pudp_demux

Parametrised successor to the per-type PUDP packet decoder in `boe_top/eth`. It accepts a byte-wide AXI-Stream of PUDP packets (type byte, payload, XOR checksum byte) and validates each packet. It steers the payload of every good packet into one of `NUM_CH` per-channel store-and-forward buffers. Packets with a bad checksum, an unknown type, a runt length or insufficient buffer space are dropped whole, so no partial or corrupt packet ever reaches a consumer.

## Interface
- `NUM_CH`, 4: number of output channels; legal 1..16.
- `DEPTH`, 2048: per-channel buffer depth in payload bytes; power of two, at least 16.
- `clki` in 1: clock.
- `rsti_n` in 1: asynchronous active-low reset.
- `s_axis_tvalid` in 1: input byte valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tdata` in 8: input byte.
- `s_axis_tlast` in 1: last byte of the packet (the checksum byte).
- `m_axis_tvalid` out `NUM_CH`: per-channel output valid.
- `m_axis_tready` in `NUM_CH`: per-channel output ready.
- `m_axis_tdata` out `NUM_CH*8`: channel c occupies bits [8c+7:8c].
- `m_axis_tlast` out `NUM_CH`: last payload byte of the packet.
- `stat_good` out `NUM_CH*16`: per-channel count of good packets (present only with `PUDP_DEMUX_STATS_EN`).
- `stat_drop` out 4x16: drop counts for checksum, overflow, bad type and runt (present only with `PUDP_DEMUX_STATS_EN`).

## Operation
- Packet format:
  - Byte 0 is the type.
  - Bytes 1..n-2 are the payload.
  - Byte n-1 is the checksum, equal to the XOR of bytes 0..n-2.
  - The minimum packet length is 3 bytes.
- A byte is accepted when `s_axis_tvalid && s_axis_tready`. `s_axis_tready` is 1 whenever the block is out of reset. The block never stalls the input; it drops packets instead.
- Input FSM:
  - IDLE: the accepted byte is stored as the type, the running XOR is set to that byte, and the FSM goes to BODY. If `tlast` is set on this byte, the packet is a runt: it is dropped and the FSM stays in IDLE.
  - BODY: each accepted byte is XORed into the running value. The previous byte is written to channel `type` at the tentative write pointer. If `tlast` is set on the first BODY byte, the packet is a runt and is dropped. On `tlast` otherwise: commit if the running XOR equals the last byte and the packet is not flagged, else roll back. The FSM returns to IDLE in both cases.
  - The payload byte preceding the checksum is written with its last flag set to 1.
- The drop flag is set in three cases:
  - `type >= NUM_CH`: nothing is written.
  - The tentative occupancy (tentative write pointer minus read pointer) reaches `DEPTH` while a further write is pending: writes stop and the rest of the packet is consumed silently.
  - Any runt, as described above.
- Commit copies the tentative write pointer to the committed write pointer. Rollback restores the tentative pointer from the committed pointer.
- The read side sees only committed entries. Each entry is 9 bits: 8 data bits plus the last flag.
- The output stage is a standard AXI-Stream register. `tdata` and `tlast` hold stable while `tvalid && !tready`.
- Pointers are `$clog2(DEPTH)+1` bits wide and wrap modulo 2·DEPTH. Full is `wr_tent - rd == DEPTH`. Empty is `wr_commit == rd`.

## Timing
- Commit happens on the edge that accepts the checksum byte.
- The first payload byte is presented on `m_axis_tvalid` no earlier than 2 cycles after commit: 1 cycle of RAM read plus 1 cycle of output register.
- With `m_axis_tready` held at 1, a committed packet of P bytes drains in P consecutive cycles.
- A write (commit) and a read on the same channel in the same cycle are legal. Full and empty are evaluated against pre-edge pointers, with no bypass.
- Reset values:
  - `s_axis_tready`, all `m_axis_*` and all counters are 0.
  - All pointers are 0 and the FSM is in IDLE.
  - A packet in flight at reset is lost. The first byte accepted after reset deasserts is treated as a type byte.

## Configuration
- `PUDP_DEMUX_STATS_EN` defined: `stat_good` and `stat_drop` exist as 16-bit saturating counters. Each counter increments on the edge that accepts the `tlast` of the corresponding packet.
- `PUDP_DEMUX_STATS_EN` undefined: the counters and both ports are absent, and datapath behaviour is identical.

## Structure
- Package `pudp_pkg` holds:
  - `PUDP_MIN_LEN` = 3;
  - the FSM enum `pudp_st_e` {IDLE, BODY};
  - the drop-reason enum `pudp_drop_e` {CKSUM, OVFL, BADTYPE, RUNT};
  - the 9-bit entry struct `pudp_ent_t`.
- Sub-module `pudp_pkt_fifo`, instantiated once per channel, covers the per-channel datapath:
  - ports: tentative write, commit and rollback strobes, free-space flag, and the AXI-Stream read side;
  - storage: inferred simple dual-port RAM.

## Test plan
- Good packet: `NUM_CH`=4, send 02 AA BB 13 (`tlast` on 13) → channel 2 outputs AA then BB with `tlast` on BB; other channels stay idle; `stat_good[2]` = 1.
- Bad checksum: send 02 AA BB 14 → no output on any channel; checksum drop count = 1; a following good packet passes normally.
- Bad type and runt: send 05 AA AF, then 01 01, then 01 → no output on any channel; bad-type drop count = 1, runt drop count = 2.
- Overflow: `DEPTH`=16, `m_axis_tready[0]`=0, send three type-0 packets of 7 payload bytes each → first two commit and third is dropped (overflow drop count = 1); after raising `tready`, exactly 14 bytes drain with 2 `tlast`s.
- Backpressure and concurrency:
  - Toggle `m_axis_tready[1]` randomly while streaming packets to channels 1 and 3 → data stays stable under stall and each channel's byte order matches its reference model.
  - Assert `rsti_n` low mid-packet → all outputs go to 0; after release, packet 00 55 55 → channel 0 outputs 55 with `tlast`.
